// File: rtl/arb_types_pkg.sv
// Shared types and default geometry for the cache-line memory arbiter.
package arb_types_pkg;

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} arb_state_t;

  typedef enum logic {GNT_I, GNT_D} grant_t;

  localparam int DEF_LINE_W  = 256;
  localparam int DEF_BEAT_W  = 64;
  localparam int BEATS       = DEF_LINE_W / DEF_BEAT_W;
  localparam int OFFSET_BITS = $clog2(DEF_LINE_W / 8);

endpackage

// File: rtl/line_burst_adapter.sv
// Beat counter plus a shared line buffer that assembles read beats into a line
// and slices a captured write-back line into beats.
module line_burst_adapter
  import arb_types_pkg::*;
#(
  parameter  int LINE_W  = DEF_LINE_W,
  parameter  int BEAT_W  = DEF_BEAT_W,
  localparam int N_BEATS = LINE_W / BEAT_W,
  localparam int CNT_W   = $clog2(N_BEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              rd_active,
  input  logic              wr_active,
  input  logic              mem_resp,
  input  logic [BEAT_W-1:0] mem_rdata,
  output logic              last_beat,
  output logic [LINE_W-1:0] line,
  output logic [BEAT_W-1:0] wr_beat
);

  logic [CNT_W-1:0] beat;
  logic             beat_fire;

  assign beat_fire = (rd_active | wr_active) & mem_resp;
  assign last_beat = (beat == CNT_W'(N_BEATS - 1));
  assign wr_beat   = line[int'(beat) * BEAT_W +: BEAT_W];

  // The counter wraps to zero on the final beat so the next burst starts clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat <= '0;
      line <= '0;
    end else begin
      if (load) begin
        line <= load_line;
      end else if (rd_active && mem_resp) begin
        line[int'(beat) * BEAT_W +: BEAT_W] <= mem_rdata;
      end
      if (beat_fire) begin
        beat <= last_beat ? '0 : beat + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one burst memory port.
// Define ARB_ROUND_ROBIN_EN to alternate grants on collisions; default is fixed D-cache priority.
module cacheline_mem_arbiter
  import arb_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = DEF_LINE_W,
  parameter int BEAT_W = DEF_BEAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  arb_state_t        state, state_nxt;
  grant_t            gnt;
  logic              write_op;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] i_line_q, d_line_q;
  logic              d_req, pick_d, start;
  logic              rd_active, wr_active, last_beat;
  logic [LINE_W-1:0] line;
  logic [BEAT_W-1:0] wr_beat;

  assign d_req = d_read | d_write;
  assign start = (state == IDLE) && (d_req || i_read);

`ifdef ARB_ROUND_ROBIN_EN
  grant_t last_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= GNT_I;
    end else if (start) begin
      last_grant <= pick_d ? GNT_D : GNT_I;
    end
  end

  assign pick_d = d_req & (~i_read | (last_grant == GNT_I));
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DONE never samples requests, giving the cache a cycle to drop its request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_d) begin
          state_nxt = d_write ? D_WR : D_RD;
        end else if (i_read) begin
          state_nxt = I_RD;
        end
      end
      I_RD, D_RD, D_WR: begin
        if (mem_resp && last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt      <= GNT_I;
      write_op <= 1'b0;
      addr_q   <= '0;
    end else if (start) begin
      gnt      <= pick_d ? GNT_D : GNT_I;
      write_op <= pick_d & d_write;
      addr_q   <= (pick_d ? d_addr : i_addr) & ALIGN_MASK;
    end
  end

  // Returned lines are held until the same port completes another read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_line_q <= '0;
      d_line_q <= '0;
    end else begin
      if (i_resp) begin
        i_line_q <= line;
      end
      if (d_resp && !write_op) begin
        d_line_q <= line;
      end
    end
  end

  line_burst_adapter #(
    .LINE_W(LINE_W),
    .BEAT_W(BEAT_W)
  ) u_adapter (
    .clk      (clk),
    .reset    (reset),
    .load     (start & pick_d & d_write),
    .load_line(d_wdata),
    .rd_active(rd_active),
    .wr_active(wr_active),
    .mem_resp (mem_resp),
    .mem_rdata(mem_rdata),
    .last_beat(last_beat),
    .line     (line),
    .wr_beat  (wr_beat)
  );

  assign rd_active = (state == I_RD) || (state == D_RD);
  assign wr_active = (state == D_WR);

  assign mem_read  = rd_active;
  assign mem_write = wr_active;
  assign mem_addr  = addr_q;
  assign mem_wdata = wr_active ? wr_beat : '0;

  assign i_resp  = (state == DONE) && (gnt == GNT_I);
  assign d_resp  = (state == DONE) && (gnt == GNT_D);
  assign i_rdata = i_resp ? line : i_line_q;
  assign d_rdata = (d_resp && !write_op) ? line : d_line_q;

endmodule
